// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, the multiply sequencer state type and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_XLEN = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the external ALU's ADD path, one iteration per clock.
// Optional macro MUL_SEQ_EARLY_EXIT_EN ends the run as soon as no multiplier bits remain.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_prod,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    mul_state_t       state;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rs1_hold;
    logic [XLEN-1:0]  rs2_hold;
    logic             last_iter;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign last_iter = (cnt == LAST_CNT) || (mplier[XLEN-1:1] == '0);
`else
    assign last_iter = (cnt == LAST_CNT);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign alu_own   = (state == RUN);
    assign out_prod  = acc;
    assign alu_ctrl  = ALU_ADD;

    // Outside RUN the ALU operands keep showing whatever was last driven during the run.
    assign alu_rs1 = (state == RUN) ? acc   : rs1_hold;
    assign alu_rs2 = (state == RUN) ? mcand : rs2_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            rs1_hold <= '0;
            rs2_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        mcand  <= in_a;
                        mplier <= in_b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= alu_out;
                    end
                    mcand    <= {mcand[XLEN-2:0], 1'b0};
                    mplier   <= {1'b0, mplier[XLEN-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                    rs1_hold <= acc;
                    rs2_hold <= mcand;
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq; honours MUL_SEQ_EARLY_EXIT_EN when computing expected latency.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic        alu_own;
    logic [63:0] alu_rs1;
    logic [63:0] alu_rs2;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the core's combinational ALU.
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            ALU_ADD: alu_out = alu_rs1 + alu_rs2;
            ALU_SUB: alu_out = alu_rs1 - alu_rs2;
            ALU_AND: alu_out = alu_rs1 & alu_rs2;
            ALU_OR:  alu_out = alu_rs1 | alu_rs2;
            default: alu_out = '0;
        endcase
    end

    alu_mul_seq #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .alu_own   (alu_own),
        .alu_rs1   (alu_rs1),
        .alu_rs2   (alu_rs2),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycles from the accept edge until out_valid is first seen.
    function automatic int exp_latency(input logic [63:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int hb;
        hb = -1;
        for (int i = 0; i < 64; i++) if (b[i]) hb = i;
        return 1 + (((hb + 1) > 1) ? (hb + 1) : 1);
`else
        return 65;
`endif
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int hold, input string tag);
        logic [63:0] prod;
        logic [63:0] mask;
        int n;
        prod = a * b;
        check({tag, " ready_before"}, 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        n = 1;
        while (!out_valid && n < 200) begin
            mask = (n == 1) ? 64'd0 : ({64{1'b1}} >> (65 - n));
            check({tag, " own"},   64'(alu_own), 64'd1);
            check({tag, " ready"}, 64'(in_ready), 64'd0);
            check({tag, " ctrl"},  64'(alu_ctrl), 64'(ALU_ADD));
            check({tag, " rs1"},   alu_rs1, a * (b & mask));
            check({tag, " rs2"},   alu_rs2, a << (n - 1));
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_latency(b)));
        check({tag, " prod"}, out_prod, prod);
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            @(negedge clk);
            check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold_prod"},  out_prod, prod);
            check({tag, " hold_ready"}, 64'(in_ready), 64'd0);
            check({tag, " hold_own"},   64'(alu_own), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, " ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ba [3];
        logic [63:0] bb [3];
        logic [63:0] ra;
        logic [63:0] rb;
        int n;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(negedge clk);
        check("rst in_ready",  64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst alu_own",   64'(alu_own), 64'd0);
        check("rst out_prod",  out_prod, 64'd0);
        check("rst rs1",       alu_rs1, 64'd0);
        check("rst rs2",       alu_rs2, 64'd0);
        check("rst ctrl",      64'(alu_ctrl), 64'(ALU_ADD));
        rst = 1'b0;
        @(negedge clk);

        run_op(64'd3, 64'd5, 0, "3x5");
        run_op({64{1'b1}}, {64{1'b1}}, 0, "wrap");
        run_op(64'h8000_0000_0000_0000, 64'd2, 0, "msb_drop");
        run_op(64'd12345, 64'd0, 0, "b_zero");
        run_op(64'd99, 64'd1, 0, "b_one");
        run_op(64'hDEAD_BEEF_0123_4567, 64'h0000_0000_0F0F_0F0F, 10, "stall");

        // Reset in the middle of a long run must discard the result.
        in_a     = 64'd11;
        in_b     = 64'h8000_0000_0000_0003;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready",  64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst alu_own",   64'(alu_own), 64'd0);
        check("midrst out_prod",  out_prod, 64'd0);
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("midrst no_output", 64'(seen), 64'd0);
        run_op(64'd7, 64'd6, 0, "7x6");

        for (int r = 0; r < 8; r++) begin
            ra = {$urandom, $urandom};
            rb = r[0] ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            run_op(ra, rb, $urandom_range(0, 3), $sformatf("rand%0d", r));
        end

        // Back-to-back with in_valid and out_ready held high.
        ba[0] = 64'd2;  bb[0] = 64'd3;
        ba[1] = 64'd10; bb[1] = 64'd10;
        ba[2] = 64'd0;  bb[2] = 64'd9;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = ba[0];
        in_b      = bb[0];
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b%0d ready", k), 64'(in_ready), 64'd1);
            check($sformatf("b2b%0d idle_valid", k), 64'(out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("b2b%0d accepted", k), 64'(alu_own), 64'd1);
            if (k < 2) begin
                in_a = ba[k+1];
                in_b = bb[k+1];
            end
            n = 1;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("b2b%0d latency", k), 64'(n), 64'(exp_latency(bb[k])));
            check($sformatf("b2b%0d prod", k), out_prod, ba[k] * bb[k]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b final_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("b2b no_extra", 64'(alu_own), 64'd0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes 64-bit multiplication by time-sharing the existing combinational ALU's ADD path, one shift-and-add iteration per clock.
- Sits beside the execute stage and accepts an operand pair over a valid/ready handshake.
- While busy it drives the ALU operand and control inputs; the core muxes ALU ownership using alu_own.
- Returns the low XLEN bits of the product, which is identical for signed and unsigned operands.

Parameters:
- XLEN, 64, operand, product and ALU width.
- CNT_W, 7, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  XLEN  multiplicand
- in_b  in  XLEN  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_prod  out  XLEN  low XLEN bits of in_a*in_b
- alu_own  out  1  high while the sequencer needs the ALU
- alu_rs1  out  XLEN  ALU operand 1 (accumulator)
- alu_rs2  out  XLEN  ALU operand 2 (shifted multiplicand)
- alu_ctrl  out  4  ALU control code
- alu_out  in  XLEN  ALU combinational result

Behaviour:
- One clock. Reset is synchronous and active-high; there is no asynchronous reset.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; alu_own=0
  - out_prod=0, alu_rs1=0, alu_rs2=0
  - alu_ctrl=ALU_ADD (4'b0010)
  - internal acc, mcand, mplier and cnt all 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=0, mcand<=in_a, mplier<=in_b, cnt<=0, then go to RUN.
- RUN (one iteration per cycle):
  - in_ready=0, alu_own=1, alu_rs1=acc, alu_rs2=mcand, alu_ctrl=ALU_ADD.
  - If mplier[0]=1, acc<=alu_out; otherwise acc holds.
  - mcand<=mcand<<1, dropping the MSB; mplier<=mplier>>1 with logical shift; cnt<=cnt+1.
  - Go to DONE after the iteration where cnt==XLEN-1.
- DONE:
  - out_valid=1 and out_prod=acc, both stable until out_ready.
  - On out_ready: go to IDLE and drop out_valid the following cycle.
- Arithmetic:
  - All values are modulo 2**XLEN and overflow is discarded.
  - Operands are captured at accept; in_a and in_b changes afterwards are ignored.
- Latency: accept at cycle T, RUN during T+1..T+64, out_valid high from T+65.
- Throughput: no overlap. A new accept is possible in the cycle after the output handshake, because in_ready is high only in IDLE.
- alu_own is 0 in IDLE and DONE, and alu_rs1/rs2 hold their last values there.
- The sequencer never uses ALU zero, SUB, AND or OR.
- out_ready while not in DONE: ignored.
- in_valid while busy: ignored, not queued.
- rst asserted mid-RUN or in DONE: the next cycle shows reset values, and the pending result is discarded without an out_valid pulse.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- Defined:
  - In RUN, go to DONE after any iteration whose shifted mplier is zero, or when cnt==XLEN-1.
  - Latency becomes T+1+max(1, index of highest set bit of in_b + 1).
  - in_b=0 or in_b=1 gives out_valid at T+2.
- Undefined: fixed 64-iteration latency, out_valid at T+65 for every operand.
- The result is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110
  - the FSM state enum mul_state_t {IDLE, RUN, DONE}
  - the default XLEN=64
- No sub-module: the FSM, shift registers and counter stay in one module. The ALU is instantiated outside, in the bench or core, and connected through the alu_* ports.

Test Plan:
- Reset, then accept a=3, b=5 at T -> alu_own high T+1..T+64; out_valid at T+65 with out_prod=15 (early-exit build: out_valid at T+4).
- a=64'hFFFF_FFFF_FFFF_FFFF, b=64'hFFFF_FFFF_FFFF_FFFF -> out_prod=1, which checks wrap-around modulo 2**64.
- a=64'h8000_0000_0000_0000, b=2 -> out_prod=0; a=12345, b=0 -> out_prod=0 (early-exit build: out_valid at T+2).
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_prod stable and in_ready=0; pulse in_valid during this time -> no accept.
- Assert rst at T+20 mid-RUN -> next cycle state IDLE, in_ready=1, out_valid=0; no result is ever emitted; a fresh a=7, b=6 then yields 42.
- Back-to-back: out_ready tied 1, issue 3 operations with in_valid held -> each accept occurs one cycle after the previous output handshake; products are 2*3=6, 10*10=100, 0*9=0.
